// File: rtl/pixel_stream_processor.sv
// pixel_stream_processor
//
// Single-stage streaming pixel processor. Each accepted pixel is transformed
// per channel (pass, invert, saturating add/sub, threshold) and presented on
// the output register the following cycle, tagged with frame position flags.
//
// Parameters:
//   CH_W    bits per colour channel
//   NUM_CH  channels per pixel (pixel width = NUM_CH*CH_W)
//   IMG_W   pixels per line (>= 2)
//   IMG_H   lines per frame (>= 2)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   in_valid     input pixel valid
//   in_ready     input pixel accepted this cycle when in_valid is high
//   in_data      input pixel, channel k at [k*CH_W +: CH_W]
//   mode         operation select, sampled with each accepted pixel
//   offset       brightness offset for the add/sub modes
//   threshold    threshold for the binarise mode
//   out_valid    output pixel valid
//   out_ready    downstream accepts the output pixel
//   out_data     processed pixel
//   out_sof      output beat is the first pixel of a frame
//   out_eol      output beat is the last pixel of a line
//   out_eof      output beat is the last pixel of a frame
//   frame_count  number of frames whose last beat has been delivered (wraps)

module pixel_stream_processor #(
  parameter int unsigned CH_W   = 8,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*CH_W-1:0]   in_data,
  input  logic [2:0]               mode,
  input  logic [CH_W-1:0]          offset,
  input  logic [CH_W-1:0]          threshold,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*CH_W-1:0]   out_data,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic                     out_eof,
  output logic [15:0]              frame_count
);

  localparam int unsigned PW = NUM_CH * CH_W;
  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // Per-channel operation; all arithmetic is unsigned with one guard bit to
  // detect overflow (add) and underflow (sub).
  function automatic logic [CH_W-1:0] proc_ch(input logic [2:0]      op,
                                               input logic [CH_W-1:0] px,
                                               input logic [CH_W-1:0] off,
                                               input logic [CH_W-1:0] thr);
    logic [CH_W:0]   sum;
    logic [CH_W:0]   diff;
    logic [CH_W-1:0] res;
    sum  = {1'b0, px} + {1'b0, off};
    diff = {1'b0, px} - {1'b0, off};
    case (op)
      3'd0:    res = px;
      3'd1:    res = ~px;
      3'd2:    res = sum[CH_W] ? {CH_W{1'b1}} : sum[CH_W-1:0];
      3'd3:    res = diff[CH_W] ? {CH_W{1'b0}} : diff[CH_W-1:0];
      3'd4:    res = (px >= thr) ? {CH_W{1'b1}} : {CH_W{1'b0}};
      default: res = px;
    endcase
    return res;
  endfunction

  // State
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] out_data_q, out_data_d;
  logic          out_sof_q, out_sof_d;
  logic          out_eol_q, out_eol_d;
  logic          out_eof_q, out_eof_d;
  logic [15:0]   frame_count_q, frame_count_d;

  logic          accept;
  logic          xfer;
  logic          x_last;
  logic          y_last;
  logic [PW-1:0] proc_pix;

  // Gating with reset keeps the input side closed during a reset cycle.
  assign in_ready = reset & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid_q & out_ready;

  assign x_last = (x_q == XW'(IMG_W - 1));
  assign y_last = (y_q == YW'(IMG_H - 1));

  always_comb begin
    proc_pix = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      proc_pix[k*CH_W +: CH_W] = proc_ch(mode, in_data[k*CH_W +: CH_W], offset, threshold);
    end
  end

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_sof_d     = out_sof_q;
    out_eol_d     = out_eol_q;
    out_eof_d     = out_eof_q;
    frame_count_d = frame_count_q;

    // Count a frame only when its last beat actually leaves the block.
    if (xfer && out_eof_q) begin
      frame_count_d = frame_count_q + 16'd1;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = proc_pix;
      out_sof_d   = (x_q == '0) && (y_q == '0);
      out_eol_d   = x_last;
      out_eof_d   = x_last && y_last;
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q           <= '0;
      y_q           <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sof_q     <= 1'b0;
      out_eol_q     <= 1'b0;
      out_eof_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sof_q     <= out_sof_d;
      out_eol_q     <= out_eol_d;
      out_eof_q     <= out_eof_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_sof     = out_sof_q;
  assign out_eol     = out_eol_q;
  assign out_eof     = out_eof_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_stream_processor.sv
// Testbench for pixel_stream_processor (small 4x2 frame, default 8-bit x 3 channels).
module tb_pixel_stream_processor;

  localparam int CH_W   = 8;
  localparam int NUM_CH = 3;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int PW     = CH_W * NUM_CH;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic [2:0]    mode;
  logic [7:0]    offset;
  logic [7:0]    threshold;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;
  logic [15:0]   frame_count;

  int total = 0;
  int bad   = 0;

  // Reference model state: what the output side should be showing.
  logic          m_valid = 1'b0;
  logic [PW-1:0] m_data  = '0;
  logic          m_sof   = 1'b0;
  logic          m_eol   = 1'b0;
  logic          m_eof   = 1'b0;
  int            m_fc    = 0;
  int            m_idx   = 0;  // pixel index within the frame of the next accepted pixel

  pixel_stream_processor #(
    .CH_W  (CH_W),
    .NUM_CH(NUM_CH),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mode       (mode),
    .offset     (offset),
    .threshold  (threshold),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] ref_pix(int m, logic [PW-1:0] d, int off, int thr);
    logic [PW-1:0] res;
    res = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      int v;
      int r;
      v = int'(d[k*CH_W +: CH_W]);
      case (m)
        1:       r = 255 - v;
        2:       r = (v + off > 255) ? 255 : v + off;
        3:       r = (v - off < 0) ? 0 : v - off;
        4:       r = (v >= thr) ? 255 : 0;
        default: r = v;
      endcase
      res[k*CH_W +: CH_W] = r[7:0];
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the
  // model by what the handshake rules say happens at the edge.
  task automatic tick();
    logic exp_rdy;
    logic acc;
    logic xf;
    @(negedge clk);
    exp_rdy = rst_n && (!m_valid || out_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_flags", {29'd0, out_sof, out_eol, out_eof}, {29'd0, m_sof, m_eol, m_eof});
    end
    acc = in_valid && exp_rdy;
    xf  = m_valid && out_ready;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_sof   = 1'b0;
      m_eol   = 1'b0;
      m_eof   = 1'b0;
      m_fc    = 0;
      m_idx   = 0;
    end else begin
      if (xf && m_eof) m_fc = (m_fc + 1) % 65536;
      if (acc) begin
        m_valid = 1'b1;
        m_data  = ref_pix(int'(mode), in_data, int'(offset), int'(threshold));
        m_sof   = (m_idx == 0);
        m_eol   = (m_idx % IMG_W) == IMG_W - 1;
        m_eof   = (m_idx == IMG_W * IMG_H - 1);
        m_idx   = (m_idx + 1) % (IMG_W * IMG_H);
      end else if (xf) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic drive(input logic [2:0] m, input logic [PW-1:0] d, input logic [7:0] off,
                       input logic [7:0] thr);
    in_valid  = 1'b1;
    mode      = m;
    in_data   = d;
    offset    = off;
    threshold = thr;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 24'hABCDEF;
    mode      = 3'd0;
    offset    = 8'd0;
    threshold = 8'd0;
    out_ready = 1'b1;

    // Reset: nothing accepted, outputs cleared.
    repeat (3) tick();
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_flags", {29'd0, out_sof, out_eol, out_eof}, 32'h0);
    rst_n = 1'b1;

    // Directed per-mode vectors.
    drive(3'd0, 24'h12AB34, 8'h00, 8'h00);
    tick();
    chk("pass_data", 32'(out_data), 32'h12AB34);
    chk("pass_sof", 32'(out_sof), 32'h1);
    drive(3'd1, 24'h00FF80, 8'h00, 8'h00);
    tick();
    chk("invert_data", 32'(out_data), 32'hFF007F);
    drive(3'd2, 24'hF01000, 8'h20, 8'h00);
    tick();
    chk("add_sat_data", 32'(out_data), 32'hFF3020);
    drive(3'd3, 24'h104020, 8'h20, 8'h00);
    tick();
    chk("sub_sat_data", 32'(out_data), 32'h002000);
    chk("eol_beat3", 32'(out_eol), 32'h1);
    drive(3'd4, 24'h7F80FF, 8'h00, 8'h80);
    tick();
    chk("thresh_data", 32'(out_data), 32'h00FFFF);

    // Backpressure: held output, changing controls must not touch it.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(3'($urandom_range(0, 7)), 24'($urandom), 8'($urandom), 8'($urandom));
      tick();
      chk("stall_data", 32'(out_data), 32'h00FFFF);
    end
    out_ready = 1'b1;
    tick();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 24'($urandom);
      mode      = 3'($urandom_range(0, 7));
      offset    = 8'($urandom);
      threshold = 8'($urandom);
      tick();
    end

    // Framing on a continuous stream after a fresh reset.
    rst_n     = 1'b0;
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int b = 0; b < 10; b++) begin
      drive(3'd0, 24'($urandom), 8'h00, 8'h00);
      tick();
      chk("frm_sof", 32'(out_sof), 32'((b % 8) == 0));
      chk("frm_eol", 32'(out_eol), 32'((b % 4) == 3));
      chk("frm_eof", 32'(out_eof), 32'((b % 8) == 7));
      chk("frm_count", 32'(frame_count), 32'(b >= 8));
    end

    // Mid-frame reset discards the held beat and restarts framing.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int b = 0; b < 5; b++) begin
      drive(3'd1, 24'($urandom), 8'h00, 8'h00);
      tick();
    end
    out_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_fc", 32'(frame_count), 32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(3'd0, 24'h010203, 8'h00, 8'h00);
    tick();
    chk("midrst_sof", 32'(out_sof), 32'h1);
    chk("midrst_data", 32'(out_data), 32'h010203);
    in_valid = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_stream_processor.md
PIXEL_STREAM_PROCESSOR -- requirements
Module: pixel_stream_processor

Interface
REQ-001 Parameter CH_W, default 8, bits per colour channel.
REQ-002 Parameter NUM_CH, default 3, channels per pixel; pixel width PW = NUM_CH*CH_W (24 at defaults).
REQ-003 Parameter IMG_W, default 64, pixels per line (>=2).
REQ-004 Parameter IMG_H, default 64, lines per frame (>=2).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-007 in_valid  input  1  input pixel valid.
REQ-008 in_ready  output  1  block accepts input pixel this cycle.
REQ-009 in_data  input  PW  input pixel; channel k at bits [k*CH_W +: CH_W].
REQ-010 mode  input  3  operation select, sampled per accepted pixel.
REQ-011 offset  input  CH_W  brightness offset for modes 2/3.
REQ-012 threshold  input  CH_W  threshold for mode 4.
REQ-013 out_valid  output  1  output pixel valid.
REQ-014 out_ready  input  1  downstream accepts output.
REQ-015 out_data  output  PW  processed pixel.
REQ-016 out_sof  output  1  output beat is first pixel of frame (x=0,y=0).
REQ-017 out_eol  output  1  output beat is last pixel of a line (x=IMG_W-1).
REQ-018 out_eof  output  1  output beat is last pixel of frame (x=IMG_W-1,y=IMG_H-1).
REQ-019 frame_count  output  16  count of completed frames delivered at output.

Function
REQ-020 Input handshake: pixel accepted when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-021 in_ready SHALL equal (!out_valid || out_ready), combinationally; one output register stage, no extra buffering.
REQ-022 Latency: accepted pixel SHALL appear on out_data with out_valid=1 the next cycle.
REQ-023 While out_valid=1 and out_ready=0, out_data and all out_* flags SHALL hold stable.
REQ-024 Simultaneous output transfer and input acceptance SHALL load the new pixel with out_valid staying 1 (full throughput, one pixel/cycle).
REQ-025 Output transfer with no acceptance SHALL clear out_valid next cycle.
REQ-026 Per-channel operation, each channel independent, unsigned, result CH_W bits:
 - mode 0: pass-through.
 - mode 1: invert, 2^CH_W-1-x.
 - mode 2: x+offset, saturate at 2^CH_W-1.
 - mode 3: x-offset, saturate at 0.
 - mode 4: 2^CH_W-1 if x>=threshold else 0.
 - modes 5-7: pass-through.
REQ-027 mode, offset, threshold SHALL be sampled in the acceptance cycle; changes apply from the next accepted pixel, never to a held output.
REQ-028 Position counters x (0..IMG_W-1) and y (0..IMG_H-1) SHALL advance only on input acceptance; x wraps to 0 after IMG_W-1 and increments y; y wraps to 0 after last pixel of frame.
REQ-029 out_sof/out_eol/out_eof SHALL be registered from the accepted pixel's x,y, aligned with its out_data.
REQ-030 frame_count SHALL increment by 1 on the output transfer of an out_eof beat; wraps 0xFFFF->0x0000.
REQ-031 Stall (out_ready=0) SHALL not advance counters or lose/duplicate pixels.

Reset
REQ-032 When reset=0 at a clock edge: out_valid=0, out_data=0, out_sof=out_eol=out_eof=0, x=0, y=0, frame_count=0.
REQ-033 in_ready SHALL be 0 while reset=0; no pixel accepted in a reset cycle.
REQ-034 Reset mid-frame SHALL discard any held output; first pixel after release is flagged out_sof=1.

Verification
REQ-035 Pass/invert at defaults: mode 0 in_data=0x12AB34 -> next cycle out_data=0x12AB34, out_sof=1; mode 1 in 0x00FF80 -> 0xFF007F.
REQ-036 Saturation: mode 2 offset=0x20, in 0xF01000 -> 0xFF3020; mode 3 offset=0x20, in 0x104020 -> 0x002000; mode 4 threshold=0x80, in 0x7F80FF -> 0x00FFFF.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stable; release -> pixels delivered in order, none lost/duplicated.
REQ-038 Framing, IMG_W=4, IMG_H=2, continuous stream: out_eol on beats 3 and 7, out_eof and frame_count 0->1 on beat 7, out_sof on beat 8.
REQ-039 Reset mid-frame after 5 pixels (IMG_W=4) -> out_valid=0 next cycle, frame_count=0; next accepted pixel gives out_sof=1.
